// File: rtl/collatz_pkg.sv
// +------------------------------------------------------------------+
// | collatz_pkg : shared state codes and error codes for the Collatz |
// | iterator.                                                         |
// | Revision   : 1.0                                                  |
// +------------------------------------------------------------------+
`default_nettype none

package collatz_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   localparam logic [1:0] ERR_OK   = 2'b00;
   localparam logic [1:0] ERR_ZERO = 2'b01;
   localparam logic [1:0] ERR_OVF  = 2'b10;
   localparam logic [1:0] ERR_SAT  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/collatz_step.sv
// +------------------------------------------------------------------+
// | collatz_step : one combinational Collatz step with overflow flag. |
// | Revision     : 1.0                                                |
// +------------------------------------------------------------------+
`default_nettype none

module collatz_step #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] cur,
   output logic [WIDTH-1:0] next,
   output logic             ovf
);

   logic [WIDTH+1:0] w_ext;
   logic [WIDTH+1:0] w_tri;

   // 3n+1 is formed two bits wider so any carry out of WIDTH is visible.
   assign w_ext = {2'b00, cur};
   assign w_tri = (w_ext << 1) + w_ext + {{(WIDTH+1){1'b0}}, 1'b1};

   assign next = cur[0] ? w_tri[WIDTH-1:0] : (cur >> 1);
   assign ovf  = cur[0] & (|w_tri[WIDTH+1:WIDTH]);

endmodule

`default_nettype wire

// File: rtl/collatz_iterator.sv
// +------------------------------------------------------------------+
// | collatz_iterator : runs Collatz steps from a start value to 1 and |
// | reports stopping time, peak value and error code.                 |
// | Optional peak tracking is built when COLLATZ_PEAK_EN is defined.  |
// | Revision         : 1.0                                            |
// +------------------------------------------------------------------+
`default_nettype none

module collatz_iterator
   import collatz_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] start_value,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [CNT_W-1:0] res_steps,
   output logic [WIDTH-1:0] res_peak,
   output logic [1:0]       res_err,
   output logic             busy
);

   localparam logic [CNT_W-1:0] c_STEPS_MAX = '1;
   localparam logic [CNT_W-1:0] c_STEP_ONE  = CNT_W'(1);
   localparam logic [WIDTH-1:0] c_CUR_ONE   = WIDTH'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cur_q,   cur_d;
   logic [CNT_W-1:0] steps_q, steps_d;
   logic [1:0]       err_q,   err_d;

   logic [WIDTH-1:0] w_next;
   logic             w_ovf;
   logic             w_accept;
   logic             w_advance;

   collatz_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .cur  (cur_q),
      .next (w_next),
      .ovf  (w_ovf)
   );

   assign w_accept  = (state_q == ST_IDLE) && start_valid;
   assign w_advance = (state_q == ST_RUN) && (cur_q != c_CUR_ONE) && (cur_q != '0)
                      && (steps_q != c_STEPS_MAX) && !w_ovf;

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      steps_d = steps_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (start_valid) begin
               cur_d   = start_value;
               steps_d = '0;
               err_d   = ERR_OK;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (cur_q == c_CUR_ONE) begin
               err_d   = ERR_OK;
               state_d = ST_DONE;
            end else if (cur_q == '0) begin
               err_d   = ERR_ZERO;
               steps_d = '0;
               state_d = ST_DONE;
            end else if (steps_q == c_STEPS_MAX) begin
               err_d   = ERR_SAT;
               state_d = ST_DONE;
            end else if (w_ovf) begin
               // Overflowing step is not applied; cur/steps/peak keep their last good values.
               err_d   = ERR_OVF;
               state_d = ST_DONE;
            end else begin
               cur_d   = w_next;
               steps_d = steps_q + c_STEP_ONE;
            end
         end
         ST_DONE: begin
            if (res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cur_q   <= '0;
         steps_q <= '0;
         err_q   <= ERR_OK;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         steps_q <= steps_d;
         err_q   <= err_d;
      end
   end

`ifdef COLLATZ_PEAK_EN
   logic [WIDTH-1:0] peak_q, peak_d;

   always_comb begin
      peak_d = peak_q;
      if (w_accept) begin
         peak_d = start_value;
      end else if (w_advance && (w_next > peak_q)) begin
         peak_d = w_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         peak_q <= '0;
      end else begin
         peak_q <= peak_d;
      end
   end

   assign res_peak = peak_q;
`else
   logic w_unused_peak;
   assign w_unused_peak = w_accept ^ w_advance;
   assign res_peak      = '0;
`endif

   assign start_ready = (state_q == ST_IDLE);
   assign res_valid   = (state_q == ST_DONE);
   assign busy        = (state_q == ST_RUN);
   assign res_steps   = steps_q;
   assign res_err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_collatz_iterator.sv
// +------------------------------------------------------------------+
// | tb_collatz_iterator : checks two iterators (CNT_W 8 and 4) driven |
// | in lockstep against a plain-arithmetic Collatz reference.         |
// | Revision            : 1.0                                         |
// +------------------------------------------------------------------+
`default_nettype none

module tb_collatz_iterator;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_valid;
   logic [15:0] start_value;
   logic        res_ready;

   logic        sr8, rv8, bz8, sr4, rv4, bz4;
   logic [7:0]  st8;
   logic [3:0]  st4;
   logic [15:0] pk8, pk4;
   logic [1:0]  er8, er4;

   logic        o_sr [2];
   logic        o_rv [2];
   logic        o_bz [2];
   logic [31:0] o_st [2];
   logic [31:0] o_pk [2];
   logic [31:0] o_er [2];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   collatz_iterator #(.WIDTH(16), .CNT_W(8)) u_dut8 (
      .clk (clk), .rst (rst),
      .start_valid (start_valid), .start_ready (sr8), .start_value (start_value),
      .res_valid (rv8), .res_ready (res_ready), .res_steps (st8),
      .res_peak (pk8), .res_err (er8), .busy (bz8)
   );

   collatz_iterator #(.WIDTH(16), .CNT_W(4)) u_dut4 (
      .clk (clk), .rst (rst),
      .start_valid (start_valid), .start_ready (sr4), .start_value (start_value),
      .res_valid (rv4), .res_ready (res_ready), .res_steps (st4),
      .res_peak (pk4), .res_err (er4), .busy (bz4)
   );

   assign o_sr[0] = sr8;  assign o_sr[1] = sr4;
   assign o_rv[0] = rv8;  assign o_rv[1] = rv4;
   assign o_bz[0] = bz8;  assign o_bz[1] = bz4;
   assign o_st[0] = {24'd0, st8};  assign o_st[1] = {28'd0, st4};
   assign o_pk[0] = {16'd0, pk8};  assign o_pk[1] = {16'd0, pk4};
   assign o_er[0] = {30'd0, er8};  assign o_er[1] = {30'd0, er4};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Straight Collatz walk with the result rules applied in priority order.
   task automatic ref_model(input int unsigned v, input int cntw,
                            output int unsigned steps, output int unsigned peak,
                            output int unsigned err);
      int unsigned n;
      int unsigned nn;
      bit          done;
      n     = v;
      steps = 0;
      peak  = v;
      err   = 0;
      done  = 0;
      for (int i = 0; i < 2000 && !done; i++) begin
         if (n == 1) begin
            err = 0; done = 1;
         end else if (n == 0) begin
            err = 1; steps = 0; done = 1;
         end else if (steps == (1 << cntw) - 1) begin
            err = 3; done = 1;
         end else begin
            nn = (n % 2 == 0) ? n / 2 : 3 * n + 1;
            if (nn > 65535) begin
               err = 2; done = 1;
            end else begin
               n = nn;
               steps++;
               if (nn > peak) peak = nn;
            end
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s_start_ready[d%0d]", tag, i), {31'd0, o_sr[i]}, 32'd1);
         check($sformatf("%s_res_valid[d%0d]", tag, i),   {31'd0, o_rv[i]}, 32'd0);
         check($sformatf("%s_busy[d%0d]", tag, i),        {31'd0, o_bz[i]}, 32'd0);
         check($sformatf("%s_steps[d%0d]", tag, i),       o_st[i], 32'd0);
         check($sformatf("%s_peak[d%0d]", tag, i),        o_pk[i], 32'd0);
         check($sformatf("%s_err[d%0d]", tag, i),         o_er[i], 32'd0);
      end
   endtask

   // hold > 0: res_ready stays low and start_valid stays high through RUN/DONE.
   task automatic run_case(input logic [15:0] v, input int hold);
      int unsigned es [2];
      int unsigned ep [2];
      int unsigned ee [2];
      logic [31:0] rs [2];
      logic [31:0] rp [2];
      logic [31:0] re [2];
      int          rc [2];
      bit          got [2];
      int          cyc;
      ref_model(v, 8, es[0], ep[0], ee[0]);
      ref_model(v, 4, es[1], ep[1], ee[1]);
`ifndef COLLATZ_PEAK_EN
      ep[0] = 0;
      ep[1] = 0;
`endif
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++)
         check($sformatf("v%0d_idle_ready[d%0d]", v, i), {31'd0, o_sr[i]}, 32'd1);
      start_value = v;
      start_valid = 1'b1;
      res_ready   = (hold == 0);
      @(posedge clk); #1;
      if (hold == 0) start_valid = 1'b0;
      for (int i = 0; i < 2; i++)
         check($sformatf("v%0d_busy[d%0d]", v, i), {31'd0, o_bz[i]}, 32'd1);
      cyc = 0;
      got[0] = 0;
      got[1] = 0;
      while (!(got[0] && got[1]) && cyc < 400) begin
         @(posedge clk); #1;
         cyc++;
         for (int i = 0; i < 2; i++) begin
            if (!got[i] && o_rv[i]) begin
               got[i] = 1;
               rc[i]  = cyc;
               rs[i]  = o_st[i];
               rp[i]  = o_pk[i];
               re[i]  = o_er[i];
            end
         end
      end
      for (int i = 0; i < 2; i++) begin
         check($sformatf("v%0d_timeout[d%0d]", v, i), {31'd0, got[i]}, 32'd1);
         if (got[i]) begin
            check($sformatf("v%0d_latency[d%0d]", v, i), rc[i], es[i] + 1);
            check($sformatf("v%0d_steps[d%0d]", v, i),   rs[i], es[i]);
            check($sformatf("v%0d_peak[d%0d]", v, i),    rp[i], ep[i]);
            check($sformatf("v%0d_err[d%0d]", v, i),     re[i], ee[i]);
         end
      end
      if (hold > 0) begin
         for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
               check($sformatf("v%0d_hold_valid[d%0d]", v, i), {31'd0, o_rv[i]}, 32'd1);
               check($sformatf("v%0d_hold_ready[d%0d]", v, i), {31'd0, o_sr[i]}, 32'd0);
               check($sformatf("v%0d_hold_steps[d%0d]", v, i), o_st[i], es[i]);
               check($sformatf("v%0d_hold_peak[d%0d]", v, i),  o_pk[i], ep[i]);
               check($sformatf("v%0d_hold_err[d%0d]", v, i),   o_er[i], ee[i]);
            end
         end
         start_valid = 1'b0;
         res_ready   = 1'b1;
         @(posedge clk); #1;
         for (int i = 0; i < 2; i++) begin
            check($sformatf("v%0d_release_valid[d%0d]", v, i), {31'd0, o_rv[i]}, 32'd0);
            check($sformatf("v%0d_release_ready[d%0d]", v, i), {31'd0, o_sr[i]}, 32'd1);
         end
      end
      res_ready = 1'b1;
   endtask

   initial begin
      rst         = 1'b1;
      start_valid = 1'b0;
      start_value = '0;
      res_ready   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;

      run_case(16'd6, 0);
      run_case(16'd27, 5);
      run_case(16'd1, 0);
      run_case(16'd0, 0);
      run_case(16'd65535, 0);
      run_case(16'd7, 0);

      // Asynchronous reset in the middle of a run on 27.
      @(posedge clk); #1;
      start_value = 16'd27;
      start_valid = 1'b1;
      res_ready   = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      repeat (20) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_reset_outputs("midrun_rst");
      @(posedge clk); #1;
      rst = 1'b0;
      run_case(16'd6, 0);

      run_case(16'd6, 3);
      for (int k = 0; k < 6; k++)
         run_case(16'($urandom_range(1, 3000)), k % 2);
      for (int k = 0; k < 3; k++)
         run_case(16'($urandom_range(0, 65535)), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/collatz_iterator.md
Name: collatz_iterator

Overview:
- Sequential Collatz runner that sits downstream of the single-step Collatz datapath.
- Accepts a start value over a valid/ready handshake.
- Applies one Collatz step per clock until the value reaches 1.
- Returns the step count (stopping time), the peak value and an error code over a second valid/ready handshake.

Parameters:
- WIDTH, 16, bit width of start value, working value and peak.
- CNT_W, 8, bit width of step counter; the counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_valid  input  1  start value offered.
- start_ready  output  1  block can accept a start value; high only in IDLE.
- start_value  input  WIDTH  initial Collatz value.
- res_valid  output  1  result available; high only in DONE.
- res_ready  input  1  consumer accepts the result.
- res_steps  output  CNT_W  number of steps applied.
- res_peak  output  WIDTH  maximum value reached, start value included.
- res_err  output  2  00 ok, 01 zero input, 10 arithmetic overflow, 11 step counter saturated.
- busy  output  1  high in RUN.

Behaviour:
- Reset:
  - Asynchronous; takes effect immediately, including mid-run or while a result is pending.
  - State IDLE; cur, steps, peak and err cleared.
  - start_ready=1; res_valid=0; res_steps=0; res_peak=0; res_err=00; busy=0.
  - Any pending result is discarded.
- FSM states: IDLE, RUN, DONE. All outputs are registered or decoded from state; no combinational path from inputs to outputs.
- IDLE:
  - On start_valid && start_ready: cur<=start_value, peak<=start_value, steps<=0, err<=00, go to RUN.
  - start_value is ignored in all other states.
- RUN, evaluated once per cycle in this priority order:
  1. cur==1: go to DONE, err 00.
  2. cur==0: go to DONE, err 01, steps 0.
  3. steps==2^CNT_W-1: go to DONE, err 11, steps held at max.
  4. Compute next value:
     - Even: cur>>1.
     - Odd: 3*cur+1, computed at WIDTH+2 bits.
     - If any bit above WIDTH-1 is set: go to DONE, err 10, cur/steps/peak unchanged.
     - Otherwise: cur<=next, steps<=steps+1, peak<=max(peak,next).
- Latency:
  - Acceptance edge E0 enters RUN; edges E1..Ek apply k steps; edge E(k+1) enters DONE.
  - res_valid is therefore visible k+1 cycles after acceptance.
  - Input 1 yields res_valid after 1 cycle with steps=0.
- DONE:
  - res_* held stable while res_valid && !res_ready.
  - On res_ready: go to IDLE. start_ready rises the next cycle; no same-cycle accept while leaving DONE.
- Simultaneous events:
  - start_valid in DONE is ignored; the start must be re-presented in IDLE.
  - Asserting rst during RUN aborts without producing a result.

Optional Feature:
- Macro COLLATZ_PEAK_EN.
- Defined: peak register and comparator are built; res_peak behaves as above.
- Undefined: no peak logic is synthesized; res_peak is tied to 0 permanently. All other outputs and timing are identical.

Decomposition:
- Package collatz_pkg holds:
  - State enum (IDLE, RUN, DONE).
  - Error-code localparams ERR_OK, ERR_ZERO, ERR_OVF, ERR_SAT.
- Sub-module collatz_step: purely combinational, WIDTH-parameterized.
  - Input: cur.
  - Outputs: next and ovf, where ovf means 3n+1 exceeds WIDTH bits.
  - The FSM stays in collatz_iterator.

Test Plan:
- Start 6, res_ready=1 -> res_valid 9 cycles after accept; steps=8, peak=16, err=00.
- Start 27 -> steps=111, peak=9232, err=00; res held unchanged for 5 cycles with res_ready=0, then IDLE after handshake.
- Start 1 -> steps=0, peak=1, err=00 one cycle after accept. Start 0 -> steps=0, err=01.
- Start 65535 -> err=10, steps=0, peak=65535. With CNT_W=4, start 7 -> err=11, steps=15, peak=52.
- Assert rst mid-run on 27 -> outputs go to reset values immediately; next start 6 completes normally with steps=8.
- start_valid held high through RUN and DONE -> exactly one acceptance per IDLE visit. Without COLLATZ_PEAK_EN, res_peak reads 0 for all cases.
